fifo_async_wptr_full: RTL and testbench

Write-domain pointer and status stage of the SDRAM controller's asynchronous FIFO.
- Keeps the binary write pointer and produces the RAM write address and write enable.
- Registers the Gray-coded write pointer that is exported to the read domain.
- Brings the read domain's Gray read pointer in through a two-flop synchronizer and derives full, almost-full and a fill level.
- Runs entirely in the write clock domain.

---
 rtl/fifo_async_wptr_full.sv | 95 +++++++++
 tb/tb_fifo_async_wptr_full.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_async_wptr_full.sv
// fifo_async_wptr_full
// Write-domain pointer and status stage of the SDRAM controller's async FIFO.
// Keeps the binary write pointer, exports a registered Gray write pointer,
// synchronizes the read domain's Gray pointer through two flops, and derives
// full / almost-full / fill level. Everything here runs on the write clock.
//
// Ports
//   clk        write-domain clock, rising edge
//   rst_n      asynchronous active-low reset
//   winc       write request for this cycle
//   rptr_gray  Gray read pointer from the read domain (asynchronous)
//   wen        RAM write enable (combinational)
//   waddr      RAM write address
//   wptr_gray  registered Gray write pointer for the read-domain synchronizer
//   wfull      registered full flag
//   wafull     registered almost-full flag (fill level >= AFULL_TH)
//   wlevel     registered fill level as seen from the write side
module fifo_async_wptr_full #(
   parameter int ADDR_WIDTH = 4,
   parameter int AFULL_TH   = 12
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  winc,
   input  logic [ADDR_WIDTH:0]   rptr_gray,
   output logic                  wen,
   output logic [ADDR_WIDTH-1:0] waddr,
   output logic [ADDR_WIDTH:0]   wptr_gray,
   output logic                  wfull,
   output logic                  wafull,
   output logic [ADDR_WIDTH:0]   wlevel
);

   localparam logic [ADDR_WIDTH:0] AFULL_TH_L = (ADDR_WIDTH+1)'(AFULL_TH);

   logic [ADDR_WIDTH:0] wbin_q, wbin_d;
   logic [ADDR_WIDTH:0] wgray_q, wgray_d;
   logic [ADDR_WIDTH:0] rq1_q, rq2_q;
   logic [ADDR_WIDTH:0] rbin_sync;
   logic [ADDR_WIDTH:0] level_d;
   logic                wfull_q, wfull_d;
   logic                wafull_q, wafull_d;
   logic [ADDR_WIDTH:0] wlevel_q;
   logic                accept;

   // Gated by rst_n so the RAM never sees a write while the pointer is held
   // in reset.
   assign accept = winc & ~wfull_q & rst_n;

   always_comb begin
      rbin_sync = '0;
      rbin_sync[ADDR_WIDTH] = rq2_q[ADDR_WIDTH];
      for (int i = ADDR_WIDTH - 1; i >= 0; i--) begin
         rbin_sync[i] = rbin_sync[i+1] ^ rq2_q[i];
      end
   end

   always_comb begin
      wbin_d   = wbin_q + {{ADDR_WIDTH{1'b0}}, accept};
      wgray_d  = wbin_d ^ (wbin_d >> 1);
      level_d  = wbin_d - rbin_sync;
      // Full when the write pointer is exactly one lap ahead: top two Gray
      // bits inverted, the rest equal.
      wfull_d  = (wgray_d == {~rq2_q[ADDR_WIDTH:ADDR_WIDTH-1], rq2_q[ADDR_WIDTH-2:0]});
      wafull_d = (level_d >= AFULL_TH_L);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wbin_q   <= '0;
         wgray_q  <= '0;
         rq1_q    <= '0;
         rq2_q    <= '0;
         wfull_q  <= 1'b0;
         wafull_q <= 1'b0;
         wlevel_q <= '0;
      end else begin
         wbin_q   <= wbin_d;
         wgray_q  <= wgray_d;
         rq1_q    <= rptr_gray;
         rq2_q    <= rq1_q;
         wfull_q  <= wfull_d;
         wafull_q <= wafull_d;
         wlevel_q <= level_d;
      end
   end

   assign wen       = accept;
   assign waddr     = wbin_q[ADDR_WIDTH-1:0];
   assign wptr_gray = wgray_q;
   assign wfull     = wfull_q;
   assign wafull    = wafull_q;
   assign wlevel    = wlevel_q;

endmodule

// File: tb/tb_fifo_async_wptr_full.sv
module tb_fifo_async_wptr_full;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       winc = 1'b0;
   int         rd_bin = 0;
   logic [4:0] rptr_gray;
   logic       wen;
   logic [3:0] waddr;
   logic [4:0] wptr_gray;
   logic       wfull, wafull;
   logic [4:0] wlevel;

   int n_tests = 0;
   int n_fail  = 0;

   assign rptr_gray = 5'(rd_bin ^ (rd_bin >> 1));

   always #5 clk = ~clk;

   fifo_async_wptr_full #(.ADDR_WIDTH(4), .AFULL_TH(12)) dut (
      .clk(clk), .rst_n(rst_n), .winc(winc), .rptr_gray(rptr_gray),
      .wen(wen), .waddr(waddr), .wptr_gray(wptr_gray), .wfull(wfull),
      .wafull(wafull), .wlevel(wlevel)
   );

   // Behavioural model: write count and the read count the write side has
   // seen (two edges old), both as plain integers modulo 32.
   int m_wcnt, m_rs1, m_rs2, m_level, m_acc;
   bit m_full, m_afull;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_wcnt = 0; m_rs1 = 0; m_rs2 = 0; m_level = 0;
         m_full = 0; m_afull = 0;
      end else begin
         m_acc   = (winc && !m_full) ? 1 : 0;
         m_wcnt  = (m_wcnt + m_acc) % 32;
         m_level = (m_wcnt - m_rs2 + 32) % 32;
         m_full  = (m_level == 16);
         m_afull = (m_level >= 12);
         m_rs2   = m_rs1;
         m_rs1   = rd_bin % 32;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_model();
      chk("wen",       int'(wen),       (winc && !m_full && rst_n) ? 1 : 0);
      chk("waddr",     int'(waddr),     m_wcnt % 16);
      chk("wptr_gray", int'(wptr_gray), m_wcnt ^ (m_wcnt >> 1));
      chk("wfull",     int'(wfull),     int'(m_full));
      chk("wafull",    int'(wafull),    int'(m_afull));
      chk("wlevel",    int'(wlevel),    m_level);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      winc = 1'b0;
      rd_bin = 0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_wen"},    int'(wen), 0);
      chk({tag, "_waddr"},  int'(waddr), 0);
      chk({tag, "_wgray"},  int'(wptr_gray), 0);
      chk({tag, "_wfull"},  int'(wfull), 0);
      chk({tag, "_wafull"}, int'(wafull), 0);
      chk({tag, "_wlevel"}, int'(wlevel), 0);
   endtask

   logic [4:0] prev_gray;

   initial begin
      // 1: reset with winc high and a nonzero read pointer
      #2;
      winc = 1'b1;
      rd_bin = 25;           // Gray 5'b10101
      rst_n = 1'b0;
      fork
         forever begin
            @(negedge clk);
            compare_model();
         end
      join_none
      step();
      step();
      chk_all_zero("rst");
      rst_n = 1'b1;
      step();
      chk("rst_first_write_waddr", int'(waddr), 1);
      do_reset();

      // 2: fill from empty, rptr at 0
      winc = 1'b1;
      for (int i = 1; i <= 17; i++) begin
         step();
         if (i <= 16) chk("fill_waddr", int'(waddr), i % 16);
         chk("fill_wafull", int'(wafull), (i >= 12) ? 1 : 0);
         chk("fill_wfull", int'(wfull), (i >= 16) ? 1 : 0);
         if (i == 12) chk("fill_level12", int'(wlevel), 12);
         if (i == 16) begin
            chk("fill_gray16", int'(wptr_gray), 5'b11000);
            chk("fill_level16", int'(wlevel), 16);
            chk("fill_wen_blocked", int'(wen), 0);
         end
      end
      chk("full_gray_hold", int'(wptr_gray), 5'b11000);

      // 3: release from full via one read
      winc = 1'b0;
      rd_bin = 1;
      step();
      chk("rel_full_e1", int'(wfull), 1);
      step();
      chk("rel_full_e2", int'(wfull), 1);
      step();
      chk("rel_full_e3", int'(wfull), 0);
      chk("rel_level", int'(wlevel), 15);
      chk("rel_waddr", int'(waddr), 0);
      winc = 1'b1;
      step();
      chk("rel_refull", int'(wfull), 1);
      winc = 1'b0;
      do_reset();

      // 4: continuous writes across the pointer wrap, reader trailing
      for (int i = 0; i < 40; i++) begin
         rd_bin = (i - 1) & 31;
         winc = 1'b1;
         prev_gray = wptr_gray;
         step();
         chk("wrap_onebit", $countones(wptr_gray ^ prev_gray), 1);
         if (i + 1 >= 3) chk("wrap_level", int'(wlevel), 4);
         chk("wrap_nofull", int'(wfull), 0);
      end
      chk("wrap_waddr", int'(waddr), 8);
      winc = 1'b0;
      do_reset();

      // 5: write lands on the edge where the advanced read pointer is used
      winc = 1'b1;
      for (int i = 0; i < 15; i++) step();
      winc = 1'b0;
      chk("sim_level_pre", int'(wlevel), 15);
      rd_bin = 1;
      step();
      step();
      winc = 1'b1;
      step();
      chk("sim_wfull", int'(wfull), 0);
      chk("sim_level", int'(wlevel), 15);
      chk("sim_waddr", int'(waddr), 0);
      winc = 1'b0;
      do_reset();

      // 6: asynchronous reset in the middle of a burst
      winc = 1'b1;
      for (int i = 0; i < 7; i++) step();
      chk("mid_waddr_pre", int'(waddr), 7);
      #2;
      rst_n = 1'b0;
      #1;
      chk_all_zero("mid");
      step();
      rst_n = 1'b1;
      chk("mid_restart0", int'(waddr), 0);
      step();
      chk("mid_restart1", int'(waddr), 1);
      winc = 1'b0;
      step();
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
